ifetch_unit: RTL and testbench

//  Consumes the fetch PC stream, issues in-order instruction-memory reads, buffers returned words
//  in a small FIFO and presents {pc,inst} pairs to decode. Sits between the PC register and decode.
//  On redirect, flushes the buffer and discards in-flight responses.

---
 rtl/ifetch_pkg.sv | 12 +
 rtl/ifetch_fifo.sv | 53 +++++
 rtl/ifetch_unit.sv | 147 ++++++++++++++
 tb/tb_ifetch_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries; flush clears it in one cycle.
module ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;
    fetch_entry_t mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign do_pop = pop & ~empty;
    // A full FIFO may still accept a push when a pop frees the head slot.
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch unit: gated imem requests, in-flight PC queue, instruction buffer.
// Optional IFETCH_PERF_EN adds stall/flush performance counters.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_OUTST  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_valid_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            pc_ready_o,
    input  logic            jump_en_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            inst_valid_o,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    input  logic            inst_ready_i
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_stall_cnt_o,
    output logic [31:0]     perf_flush_cnt_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int QW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    logic [OW-1:0]   outst;
    logic [OW-1:0]   outst_nxt;
    logic [OW-1:0]   drop;
    logic [CW:0]     fifo_cnt;
    logic [CW+1:0]   occ;
    logic            fifo_full;
    logic            fifo_empty;
    logic            grant;
    logic            rsp;
    logic            keep;
    logic            push;
    logic            pop;
    logic [QW-1:0]   q_wr;
    logic [QW-1:0]   q_rd;
    logic [XLEN-1:0] pcq [MAX_OUTST];
    fetch_entry_t    wr_entry;
    fetch_entry_t    head;

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] q);
        return (q == QW'(MAX_OUTST - 1)) ? '0 : q + QW'(1);
    endfunction

    // Buffer slots are reserved at grant so returning data never overflows.
    assign occ = (CW+2)'(outst) + (CW+2)'(fifo_cnt);
    assign imem_req_o = rst & pc_valid_i & ~jump_en_i &
                        (occ < (CW+2)'(FIFO_DEPTH)) &
                        (outst < OW'(MAX_OUTST));
    assign imem_addr_o = rst ? pc_i : '0;
    assign grant = imem_req_o & imem_gnt_i;
    assign pc_ready_o = grant;

    assign rsp = imem_rvalid_i & (outst != '0);
    assign keep = rsp & (drop == '0);
    assign push = keep & ~jump_en_i;
    assign pop = inst_valid_o & inst_ready_i;

    always_comb begin
        outst_nxt = outst;
        if (grant && !rsp) outst_nxt = outst + OW'(1);
        else if (!grant && rsp) outst_nxt = outst - OW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outst <= '0;
            drop  <= '0;
            q_wr  <= '0;
            q_rd  <= '0;
        end else begin
            outst <= outst_nxt;
            if (jump_en_i) begin
                drop <= outst_nxt;
                q_wr <= '0;
                q_rd <= '0;
            end else begin
                if (rsp && drop != '0) drop <= drop - OW'(1);
                if (grant) q_wr <= qinc(q_wr);
                if (keep) q_rd <= qinc(q_rd);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) pcq[q_wr] <= pc_i;
    end

    always_comb begin
        wr_entry.pc   = pcq[q_rd];
        wr_entry.inst = imem_rdata_i;
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (jump_en_i),
        .din   (wr_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign inst_valid_o = ~fifo_empty;
    assign inst_o = fifo_empty ? '0 : head.inst;
    assign inst_pc_o = fifo_empty ? '0 : head.pc;

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_cnt_o <= '0;
            perf_flush_cnt_o <= '0;
        end else begin
            if (pc_valid_i && !pc_ready_o)
                perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
            if (jump_en_i)
                perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
        end
    end
`endif

    a_rvalid_outst: assert property (
        @(posedge clk) disable iff (!rst)
        imem_rvalid_i |-> outst != '0);

    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst)
        (push && fifo_full) |-> pop);

endmodule

// File: tb/tb_ifetch_unit.sv
// Scoreboard bench for ifetch_unit with a simple in-order imem model.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        pc_ready_o;
    logic        jump_en_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_stall_cnt_o;
    logic [31:0] perf_flush_cnt_o;
`endif

    ifetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .pc_valid_i    (pc_valid_i),
        .pc_i          (pc_i),
        .pc_ready_o    (pc_ready_o),
        .jump_en_i     (jump_en_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_valid_o  (inst_valid_o),
        .inst_o        (inst_o),
        .inst_pc_o     (inst_pc_o),
        .inst_ready_i  (inst_ready_i)
`ifdef IFETCH_PERF_EN
        ,
        .perf_stall_cnt_o (perf_stall_cnt_o),
        .perf_flush_cnt_o (perf_flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          grant_cnt = 0;
    int          cyc = 0;
    bit          gnt_en = 0;
    bit          rv_en = 0;
    bit          pc_en = 0;
    bit          acc = 0;
    bit          t5 = 0;
    logic [31:0] pc_q[$];
    logic [31:0] mq[$];
    logic [63:0] exp_q[$];
    int          pop_cyc[$];

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic expect_pc(input logic [31:0] pc);
        pc_q.push_back(pc);
        exp_q.push_back({pc, mdata(pc)});
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    always @(posedge clk) cyc++;

    // imem model: grants seen at negedge answered from the next negedge on
    always @(negedge clk) begin
        if (!rst) begin
            mq.delete();
            imem_rvalid_i = 1'b0;
            imem_rdata_i = '0;
            imem_gnt_i = 1'b0;
        end else begin
            if (rv_en && mq.size() > 0) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i = mdata(mq.pop_front());
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i = '0;
            end
            imem_gnt_i = gnt_en;
            if (imem_req_o && gnt_en) begin
                mq.push_back(imem_addr_o);
                acc = 1'b1;
                grant_cnt++;
            end
        end
    end

    // PC source: advance after each accepted PC
    always @(posedge clk) begin
        #1;
        if (!rst) acc = 1'b0;
        else if (acc) begin
            acc = 1'b0;
            if (pc_q.size() > 0) void'(pc_q.pop_front());
        end
        pc_valid_i = pc_en && pc_q.size() > 0;
        pc_i = (pc_q.size() > 0) ? pc_q[0] : '0;
    end

    // monitor: compare every instruction decode accepts
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && inst_valid_o && inst_ready_i) begin
            total++;
            if (t5) pop_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_inst: got pc %0h inst %0h want none",
                         inst_pc_o, inst_o);
            end else begin
                e = exp_q.pop_front();
                if ({inst_pc_o, inst_o} !== e) begin
                    bad++;
                    $display("FAIL inst_pair: got %0h/%0h want %0h/%0h",
                             inst_pc_o, inst_o, e[63:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g0;
        int n;
        bit seen;
        rst = 1'b0;
        jump_en_i = 1'b0;
        inst_ready_i = 1'b0;
        pc_valid_i = 1'b0;
        pc_i = '0;
        imem_gnt_i = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_pc_ready", 32'(pc_ready_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_inst_pc", inst_pc_o, 32'd0);
        #1 rst = 1'b1;

        // 1: three sequential fetches
        @(posedge clk); #2;
        gnt_en = 1; rv_en = 1; pc_en = 1;
        inst_ready_i = 1'b1;
        expect_pc(32'h0);
        expect_pc(32'h4);
        expect_pc(32'h8);
        wait_drain(40, "t1_drain");

        // 2: decode stalled -> buffer fills with FIFO_DEPTH entries
        inst_ready_i = 1'b0;
        g0 = grant_cnt;
        for (int i = 0; i < 6; i++) expect_pc(32'h100 + 32'(4 * i));
        repeat (20) @(posedge clk);
        #2;
        chk("t2_grants_full", 32'(grant_cnt - g0), 32'd4);
        chk("t2_pc_ready", 32'(pc_ready_o), 32'd0);
        chk("t2_valid", 32'(inst_valid_o), 32'd1);
        chk("t2_head_pc", inst_pc_o, 32'h100);
        inst_ready_i = 1'b1;
        wait_drain(60, "t2_drain");
        chk("t2_grants_all", 32'(grant_cnt - g0), 32'd6);

        // 3: redirect with two reads in flight
        rv_en = 0;
        g0 = grant_cnt;
        pc_q.push_back(32'h200);
        pc_q.push_back(32'h204);
        n = 0;
        while (grant_cnt - g0 < 2 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("t3_outst2", 32'(grant_cnt - g0), 32'd2);
        @(posedge clk); #2;
        jump_en_i = 1'b1;
        @(posedge clk); #2;
        jump_en_i = 1'b0;
        rv_en = 1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (inst_valid_o) seen = 1;
        end
        chk("t3_no_valid", 32'(seen), 32'd0);
        chk("t3_mem_drained", 32'(mq.size()), 32'd0);
        @(posedge clk); #2;
        expect_pc(32'h80);
        wait_drain(30, "t3_drain");

        // 4: grant withheld for three cycles
        gnt_en = 0;
        g0 = grant_cnt;
        expect_pc(32'h300);
        repeat (3) begin
            @(posedge clk); #2;
            chk("t4_req_held", 32'(imem_req_o), 32'd1);
            chk("t4_addr", imem_addr_o, 32'h300);
            chk("t4_pc_ready", 32'(pc_ready_o), 32'd0);
        end
        gnt_en = 1;
        wait_drain(30, "t4_drain");
        chk("t4_one_accept", 32'(grant_cnt - g0), 32'd1);

        // 5: steady state, one instruction per cycle
        t5 = 1;
        for (int i = 0; i < 8; i++) expect_pc(32'h400 + 32'(4 * i));
        wait_drain(60, "t5_drain");
        t5 = 0;
        chk("t5_pops", 32'(pop_cyc.size()), 32'd8);
        if (pop_cyc.size() == 8)
            chk("t5_throughput", 32'(pop_cyc[7] - pop_cyc[0]), 32'd7);

        // 6: async reset in the middle of a stream
        inst_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) pc_q.push_back(32'h700 + 32'(4 * i));
        repeat (10) @(posedge clk);
        #2;
        chk("t6_pre_valid", 32'(inst_valid_o), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(inst_valid_o), 32'd0);
        chk("t6_rst_req", 32'(imem_req_o), 32'd0);
        chk("t6_rst_pc_ready", 32'(pc_ready_o), 32'd0);
        chk("t6_rst_inst", inst_o, 32'd0);
        chk("t6_rst_inst_pc", inst_pc_o, 32'd0);
        chk("t6_rst_addr", imem_addr_o, 32'd0);
        pc_q.delete();
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        inst_ready_i = 1'b1;
        @(posedge clk); #2;
        expect_pc(32'h500);
        wait_drain(30, "t6_recover");

`ifdef IFETCH_PERF_EN
        gnt_en = 0;
        expect_pc(32'h600);
        n = 0;
        do begin
            @(posedge clk); #3;
            n++;
        end while (!pc_valid_i && n < 10);
        repeat (4) begin
            @(posedge clk); #3;
        end
        @(posedge clk); #3;
        gnt_en = 1;
        wait_drain(30, "t6_perf_drain");
        repeat (2) begin
            @(posedge clk); #2;
            jump_en_i = 1'b1;
            @(posedge clk); #2;
            jump_en_i = 1'b0;
        end
        @(posedge clk); #2;
        chk("t6_perf_stall", perf_stall_cnt_o, 32'd5);
        chk("t6_perf_flush", perf_flush_cnt_o, 32'd2);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
